// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types for the MLP training sequencer: fixed-point sample type,
// common fixed-point constants and the sequencer state encoding.
package mlp_train_sequencer_pkg;

  localparam int unsigned SFP_W    = 16;
  localparam int unsigned SFP_FRAC = 8;

  // Signed fixed point, Q8.8
  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE  = 16'sh0100;
  localparam sfp HALF = 16'sh0080;

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    EVAL,
    DRAIN,
    REPORT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mlp_train_sequencer_if.sv
// Sample/prediction link between the sequencer (master) and the MLP core (slave).
interface mlp_train_sequencer_if #(
  parameter int unsigned INPUTS  = 2,
  parameter int unsigned OUTPUTS = 1
);
  import mlp_train_sequencer_pkg::*;

  sfp [INPUTS-1:0]  values;
  sfp [OUTPUTS-1:0] expected;
  logic             training;
  sfp [OUTPUTS-1:0] prediction;

  modport master (output values, output expected, output training, input prediction);
  modport slave  (input values, input expected, input training, output prediction);

endinterface

// File: rtl/mlp_train_sequencer_sample_delay_line.sv
// Fixed-depth shift register carrying {valid, labels} of evaluation samples
// so they line up with the MLP prediction that arrives DEPTH cycles later.
module sample_delay_line
  import mlp_train_sequencer_pkg::*;
#(
  parameter int unsigned OUTPUTS = 1,
  parameter int unsigned DEPTH   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  sfp [OUTPUTS-1:0] in_data,
  output logic             out_valid,
  output sfp [OUTPUTS-1:0] out_data
);

  logic             valid_q [DEPTH];
  sfp [OUTPUTS-1:0] data_q  [DEPTH];

  // Shift one stage per cycle; bubbles (in_valid=0) shift through as well
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mlp_train_sequencer.sv
// Replays a register-held labelled dataset to an MLP core: per epoch one
// training pass, one evaluation pass, a drain and a one-cycle accuracy report.
// Optional macro MLP_SEQ_ROTATE_EN rotates the TRAIN start index by epoch.
module mlp_train_sequencer
  import mlp_train_sequencer_pkg::*;
#(
  parameter  int unsigned INPUTS       = 2,
  parameter  int unsigned OUTPUTS      = 1,
  parameter  int unsigned SAMPLES      = 4,
  parameter  int unsigned PRED_LATENCY = 1,
  localparam int unsigned IDX_W        = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
  localparam int unsigned CORRECT_W    = $clog2(SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_we,
  input  logic [IDX_W-1:0]      load_idx,
  input  sfp [INPUTS-1:0]       load_values,
  input  sfp [OUTPUTS-1:0]      load_expected,
  input  logic                  start,
  input  logic [15:0]           epochs,
  input  sfp                    threshold,
  mlp_train_sequencer_if.master mlp,
  output logic                  busy,
  output logic                  epoch_done,
  output logic [15:0]           epoch_idx,
  output logic [CORRECT_W-1:0]  epoch_correct,
  output logic                  done
);

  localparam int unsigned CNT_MAX = (SAMPLES > PRED_LATENCY) ? SAMPLES : PRED_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN  = CNT_W'(PRED_LATENCY - 1);

  seq_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      epochs_q, epoch_cnt;
  sfp               thr_q;
  logic [CORRECT_W-1:0] acc, acc_sum;

  sfp [INPUTS-1:0]  ds_values   [SAMPLES];
  sfp [OUTPUTS-1:0] ds_expected [SAMPLES];

  sfp [INPUTS-1:0]  values_n, values_q;
  sfp [OUTPUTS-1:0] expected_n, expected_q;
  logic             training_n, training_q, push_n, push_q;
  logic [IDX_W-1:0] sel;

  logic             head_valid, hit;
  sfp [OUTPUTS-1:0] head_data;

  // State and sample counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: fixed-length TRAIN/EVAL/DRAIN phases, loop until epochs exhausted
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (start) begin
        state_n = (epochs == '0) ? DONE : TRAIN;
        cnt_n   = '0;
      end
      TRAIN: if (cnt == LAST_SAMPLE) begin
        state_n = EVAL;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      EVAL: if (cnt == LAST_SAMPLE) begin
        state_n = DRAIN;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      DRAIN: if (cnt == LAST_DRAIN) begin
        state_n = REPORT;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      // epoch_cnt was already advanced on entry to REPORT
      REPORT:  state_n = (epoch_cnt == epochs_q) ? DONE : TRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next output values, derived from the upcoming state so outputs can be registered
  always_comb begin
    values_n   = '0;
    expected_n = '0;
    training_n = 1'b0;
    push_n     = 1'b0;
`ifdef MLP_SEQ_ROTATE_EN
    sel = IDX_W'((32'(cnt_n) + 32'(epoch_cnt)) % SAMPLES);
`else
    sel = IDX_W'(cnt_n);
`endif
    unique case (state_n)
      TRAIN: begin
        values_n   = ds_values[sel];
        expected_n = ds_expected[sel];
        training_n = 1'b1;
      end
      EVAL: begin
        values_n   = ds_values[IDX_W'(cnt_n)];
        expected_n = ds_expected[IDX_W'(cnt_n)];
        push_n     = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs toward the MLP and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      values_q   <= '0;
      expected_q <= '0;
      training_q <= 1'b0;
      push_q     <= 1'b0;
      busy       <= 1'b0;
      epoch_done <= 1'b0;
      done       <= 1'b0;
    end else begin
      values_q   <= values_n;
      expected_q <= expected_n;
      training_q <= training_n;
      push_q     <= push_n;
      busy       <= (state_n != IDLE);
      epoch_done <= (state_n == REPORT);
      done       <= (state_n == DONE);
    end
  end

  assign mlp.values   = values_q;
  assign mlp.expected = expected_q;
  assign mlp.training = training_q;

  // Dataset writes, accepted only while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SAMPLES; i++) begin
        ds_values[i]   <= '0;
        ds_expected[i] <= '0;
      end
    end else if (state == IDLE && load_we && 32'(load_idx) < SAMPLES) begin
      ds_values[load_idx]   <= load_values;
      ds_expected[load_idx] <= load_expected;
    end
  end

  sample_delay_line #(
    .OUTPUTS (OUTPUTS),
    .DEPTH   (PRED_LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push_q),
    .in_data   (expected_q),
    .out_valid (head_valid),
    .out_data  (head_data)
  );

  // A sample is correct when prediction and label fall on the same side of the threshold
  always_comb begin
    hit = head_valid;
    for (int unsigned k = 0; k < OUTPUTS; k++) begin
      if (($signed(mlp.prediction[k]) < thr_q) != ($signed(head_data[k]) < thr_q))
        hit = 1'b0;
    end
    acc_sum = acc + CORRECT_W'(hit);
  end

  // Run configuration, epoch counting and accuracy accumulation.
  // The last sample is scored on the same edge that enters REPORT, so the
  // report takes acc_sum rather than acc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epochs_q      <= '0;
      thr_q         <= '0;
      epoch_cnt     <= '0;
      acc           <= '0;
      epoch_idx     <= '0;
      epoch_correct <= '0;
    end else begin
      if (state == IDLE && start) begin
        epochs_q  <= epochs;
        thr_q     <= threshold;
        epoch_cnt <= '0;
        acc       <= '0;
      end else if (state_n == REPORT) begin
        epoch_correct <= acc_sum;
        epoch_idx     <= epoch_cnt;
        epoch_cnt     <= epoch_cnt + 16'd1;
        acc           <= '0;
      end else if (state == DONE) begin
        epoch_cnt <= '0;
      end else begin
        acc <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Randomized self-checking bench for mlp_train_sequencer with a cycle-indexed
// reference model of the replay schedule and per-epoch scoring.
module tb_mlp_train_sequencer;
  import mlp_train_sequencer_pkg::*;

  localparam int unsigned NI = 2;
  localparam int unsigned NO = 1;
  localparam int unsigned NS = 4;
  localparam int unsigned LAT = 3;
  localparam int unsigned EPOCH_LEN = 2*NS + LAT + 1;
  localparam int unsigned MAXC = 128;
`ifdef MLP_SEQ_ROTATE_EN
  localparam int unsigned ROT = 1;
`else
  localparam int unsigned ROT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_we = 1'b0;
  logic [1:0] load_idx = '0;
  sfp [NI-1:0] load_values = '0;
  sfp [NO-1:0] load_expected = '0;
  logic start = 1'b0;
  logic [15:0] epochs = '0;
  sfp threshold = '0;
  logic busy, epoch_done, done;
  logic [15:0] epoch_idx;
  logic [2:0] epoch_correct;

  mlp_train_sequencer_if #(.INPUTS(NI), .OUTPUTS(NO)) mlp();

  mlp_train_sequencer #(
    .INPUTS(NI), .OUTPUTS(NO), .SAMPLES(NS), .PRED_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .load_we(load_we), .load_idx(load_idx), .load_values(load_values),
    .load_expected(load_expected),
    .start(start), .epochs(epochs), .threshold(threshold),
    .mlp(mlp),
    .busy(busy), .epoch_done(epoch_done), .epoch_idx(epoch_idx),
    .epoch_correct(epoch_correct), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state
  sfp [NI-1:0] ds_v [NS];
  sfp [NO-1:0] ds_e [NS];
  sfp [NO-1:0] pred_hist [MAXC];
  int unsigned m_epochs;
  sfp m_thr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Correct-sample count for epoch ep from the recorded predictions
  function automatic logic [2:0] score(input int unsigned ep);
    int unsigned n, c;
    logic ok;
    n = 0;
    for (int unsigned i = 0; i < NS; i++) begin
      c  = ep*EPOCH_LEN + 1 + NS + i;
      ok = 1'b1;
      for (int unsigned k = 0; k < NO; k++)
        if (($signed(pred_hist[c+LAT][k]) < m_thr) != ($signed(ds_e[i][k]) < m_thr))
          ok = 1'b0;
      if (ok) n++;
    end
    return 3'(n);
  endfunction

  // Expected outputs during cycle j after the start edge (j=1 is the first)
  task automatic model_cycle(input int unsigned j,
                             output sfp [NI-1:0] v, output sfp [NO-1:0] e,
                             output logic tr, output logic bsy, output logic ed,
                             output logic dn, output logic [15:0] ei, output logic [2:0] ec);
    int unsigned total, ep, p, idx;
    total = m_epochs*EPOCH_LEN + 1;
    v = '0; e = '0; tr = 1'b0; ed = 1'b0; dn = 1'b0; ei = '0; ec = '0;
    bsy = (j >= 1 && j <= total);
    if (j == total) dn = 1'b1;
    else if (j < total) begin
      ep = (j-1) / EPOCH_LEN;
      p  = (j-1) % EPOCH_LEN;
      if (p < NS) begin
        idx = (p + ROT*ep) % NS;
        v = ds_v[idx]; e = ds_e[idx]; tr = 1'b1;
      end else if (p < 2*NS) begin
        v = ds_v[p-NS]; e = ds_e[p-NS];
      end else if (p == 2*NS + LAT) begin
        ed = 1'b1; ei = 16'(ep); ec = score(ep);
      end
    end
  endtask

  task automatic load(input int unsigned i, input sfp [NI-1:0] v, input sfp [NO-1:0] e);
    @(negedge clk);
    load_we = 1'b1; load_idx = 2'(i); load_values = v; load_expected = e;
    @(posedge clk);
    #1 load_we = 1'b0;
    ds_v[i] = v; ds_e[i] = e;
  endtask

  // mode: 0 echo labels after LAT cycles, 1 constant HALF-1, 2 random near threshold
  task automatic run(input int unsigned ep, input sfp thr, input int unsigned mode,
                     input bit junk, input int unsigned abort_at);
    int unsigned total;
    sfp [NI-1:0] mv; sfp [NO-1:0] me, pv;
    logic mtr, mb, med, mdn; logic [15:0] mei; logic [2:0] mec;
    m_epochs = ep; m_thr = thr;
    total = ep*EPOCH_LEN + 1;
    @(negedge clk);
    start = 1'b1; epochs = 16'(ep); threshold = thr;
    @(posedge clk);
    #1 start = 1'b0; epochs = 16'($urandom); threshold = sfp'($urandom);
    for (int unsigned j = 1; j <= total + 1; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      pv = '0;
      if (mode == 0) begin
        if (j > LAT) begin
          model_cycle(j-LAT, mv, me, mtr, mb, med, mdn, mei, mec);
          pv = me;
        end
      end else if (mode == 1) begin
        for (int unsigned k = 0; k < NO; k++) pv[k] = HALF - 16'sd1;
      end else begin
        for (int unsigned k = 0; k < NO; k++)
          case ($urandom_range(0, 3))
            0: pv[k] = thr - 16'sd1;
            1: pv[k] = thr;
            2: pv[k] = thr + 16'sd1;
            default: pv[k] = sfp'($urandom);
          endcase
      end
      pred_hist[j] = pv;
      mlp.prediction = pv;
      if (junk && j <= total) begin
        load_we = 1'($urandom); load_idx = 2'($urandom);
        load_values = 32'($urandom); load_expected = sfp'($urandom);
        start = 1'($urandom);
      end else begin
        load_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      model_cycle(j, mv, me, mtr, mb, med, mdn, mei, mec);
      check($sformatf("values@%0d", j), mlp.values, mv);
      check($sformatf("expected@%0d", j), mlp.expected, me);
      check($sformatf("training@%0d", j), mlp.training, mtr);
      check($sformatf("busy@%0d", j), busy, mb);
      check($sformatf("epoch_done@%0d", j), epoch_done, med);
      check($sformatf("done@%0d", j), done, mdn);
      if (med) begin
        check($sformatf("epoch_idx@%0d", j), epoch_idx, mei);
        check($sformatf("epoch_correct@%0d", j), epoch_correct, mec);
      end
      if (abort_at != 0 && j == abort_at) begin
        rst = 1'b0;
        #1;
        check("rst_values", mlp.values, 0);
        check("rst_expected", mlp.expected, 0);
        check("rst_training", mlp.training, 0);
        check("rst_busy", busy, 0);
        check("rst_epoch_idx", epoch_idx, 0);
        check("rst_epoch_correct", epoch_correct, 0);
        repeat (2) begin
          @(posedge clk); #1;
          check("rst_epoch_done", epoch_done, 0);
          check("rst_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int unsigned i = 0; i < NS; i++) begin ds_v[i] = '0; ds_e[i] = '0; end
        return;
      end
    end
  endtask

  task automatic load_xor();
    load(0, {16'sh0000, 16'sh0000}, 16'sh0000);
    load(1, {16'sh0000, ONE},       ONE);
    load(2, {ONE, 16'sh0000},       ONE);
    load(3, {ONE, ONE},             16'sh0000);
  endtask

  initial begin
    mlp.prediction = '0;
    for (int unsigned i = 0; i < NS; i++) begin ds_v[i] = '0; ds_e[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_values", mlp.values, 0);
    check("reset_expected", mlp.expected, 0);
    check("reset_training", mlp.training, 0);
    check("reset_busy", busy, 0);
    check("reset_epoch_done", epoch_done, 0);
    check("reset_epoch_idx", epoch_idx, 0);
    check("reset_epoch_correct", epoch_correct, 0);
    check("reset_done", done, 0);
    rst = 1'b1;

    load_xor();
    run(2, HALF, 0, 1'b0, 0);
    run(2, HALF, 1, 1'b0, 0);
    run(0, HALF, 0, 1'b0, 0);

    for (int unsigned it = 0; it < 6; it++) begin
      for (int unsigned i = 0; i < NS; i++)
        load(i, 32'($urandom), sfp'($urandom));
      run($urandom_range(0, 4), ($urandom_range(0, 1) != 0) ? HALF : sfp'($urandom),
          $urandom_range(0, 2), 1'b1, 0);
    end

    load_xor();
    run(2, HALF, 0, 1'b0, EPOCH_LEN + NS + 2);
    run(1, HALF, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
